// File: rtl/sub_n_bit_signed_serial.sv
// sub_n_bit_signed_serial: bit-serial signed subtractor, result = a - b.
// Uses one full-adder slice and a carry flop to compute a + ~b + 1, one bit per clock.
// The n+1-bit result cannot overflow.
// Optional macro SUB_SERIAL_OVF_FLAG_EN adds the output ovf_n. It is set when the
// difference does not fit in n bits.
// Timing: enable is sampled at edge k. The bit slice runs on edges k+1..k+n.
// The edge that leaves DONE (k+n+1) commits result and raises valid.
module sub_n_bit_signed_serial #(
   parameter int n = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         enable,
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   output logic         busy,
   output logic         valid,
   output logic [n:0]   result
`ifdef SUB_SERIAL_OVF_FLAG_EN
   ,
   output logic         ovf_n
`endif
);

   localparam int cnt_w = $clog2(n);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [n-1:0]       a_sr_r;
   logic [n-1:0]       nb_sr_r;
   logic [n-1:0]       acc_r;
   logic               carry_r;
   logic [cnt_w-1:0]   cnt_r;
   logic               a_sign_r;
   logic               nb_sign_r;
   logic               busy_r;
   logic               valid_r;
   logic [n:0]         result_r;
   logic               sum_s;
   logic               carry_nxt_s;
   logic               msb_s;
`ifdef SUB_SERIAL_OVF_FLAG_EN
   logic               ovf_r;
`endif

   // Carry out of a full-adder slice.
   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

   assign sum_s       = a_sr_r[0] ^ nb_sr_r[0] ^ carry_r;
   assign carry_nxt_s = maj3(a_sr_r[0], nb_sr_r[0], carry_r);
   // The sign-extended top bit of the n+1-bit sum.
   assign msb_s       = a_sign_r ^ nb_sign_r ^ carry_r;

   assign busy   = busy_r;
   assign valid  = valid_r;
   assign result = result_r;
`ifdef SUB_SERIAL_OVF_FLAG_EN
   assign ovf_n  = ovf_r;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic: IDLE -> RUN on enable, RUN for n bits, DONE lasts one cycle.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (enable) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (cnt_r == cnt_w'(n - 1)) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = RUN;
            end
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Datapath: capture operands, run the serial slice, commit the result on leaving DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr_r    <= '0;
         nb_sr_r   <= '0;
         acc_r     <= '0;
         carry_r   <= 1'b0;
         cnt_r     <= '0;
         a_sign_r  <= 1'b0;
         nb_sign_r <= 1'b0;
         busy_r    <= 1'b0;
         valid_r   <= 1'b0;
         result_r  <= '0;
`ifdef SUB_SERIAL_OVF_FLAG_EN
         ovf_r     <= 1'b0;
`endif
      end else begin
         valid_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (enable) begin
                  a_sr_r    <= a;
                  nb_sr_r   <= ~b;
                  acc_r     <= '0;
                  carry_r   <= 1'b1;
                  cnt_r     <= '0;
                  a_sign_r  <= a[n-1];
                  nb_sign_r <= ~b[n-1];
                  busy_r    <= 1'b1;
               end else begin
                  busy_r    <= 1'b0;
               end
            end
            RUN: begin
               acc_r   <= {sum_s, acc_r[n-1:1]};
               carry_r <= carry_nxt_s;
               a_sr_r  <= {1'b0, a_sr_r[n-1:1]};
               nb_sr_r <= {1'b0, nb_sr_r[n-1:1]};
               cnt_r   <= cnt_r + cnt_w'(1);
            end
            DONE: begin
               result_r <= {msb_s, acc_r};
               valid_r  <= 1'b1;
               busy_r   <= 1'b0;
`ifdef SUB_SERIAL_OVF_FLAG_EN
               ovf_r    <= msb_s ^ acc_r[n-1];
`endif
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sub_n_bit_signed_serial.sv
// tb_sub_n_bit_signed_serial: directed, table-driven bench for the serial subtractor (n=4).
module tb_sub_n_bit_signed_serial;

   localparam int n = 4;

   logic         clk;
   logic         rst_n;
   logic         enable;
   logic [n-1:0] a;
   logic [n-1:0] b;
   logic         busy;
   logic         valid;
   logic [n:0]   result;
`ifdef SUB_SERIAL_OVF_FLAG_EN
   logic         ovf_n;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [n-1:0] va;
      logic [n-1:0] vb;
      logic [n:0]   exp;
      logic         exp_ovf;
   } vec_t;

   vec_t vecs [8];

   sub_n_bit_signed_serial #(.n(n)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .valid  (valid),
      .result (result)
`ifdef SUB_SERIAL_OVF_FLAG_EN
      ,
      .ovf_n  (ovf_n)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Wait (bounded) on falling edges for valid; lat is the number of edges waited, 0 on timeout.
   task automatic wait_valid(output int lat);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (valid === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic run_op(input logic [n-1:0] ta, input logic [n-1:0] tb_v,
                         input logic [n:0] exp, input logic exp_ovf, input string nm);
      int lat;
      @(negedge clk);
      a = ta;
      b = tb_v;
      enable = 1'b1;
      @(posedge clk);
      #1;
      enable = 1'b0;
      a = ~ta;
      b = ~tb_v;
      @(negedge clk);
      check({nm, " busy_after_capture"}, 32'(busy), 32'd1);
      wait_valid(lat);
      check({nm, " latency"}, 32'(lat), 32'd5);
      check({nm, " result"}, 32'(result), 32'(exp));
`ifdef SUB_SERIAL_OVF_FLAG_EN
      check({nm, " ovf_n"}, 32'(ovf_n), 32'(exp_ovf));
`endif
      @(negedge clk);
      check({nm, " valid_one_cycle"}, 32'(valid), 32'd0);
      check({nm, " busy_low_after"}, 32'(busy), 32'd0);
      check({nm, " result_held"}, 32'(result), 32'(exp));
   endtask

   initial begin
      int lat;
      int last_cyc;
      int bad_valid;

      vecs[0] = '{4'b0011, 4'b1110, 5'b00101, 1'b0};   //  3 - (-2) = +5
      vecs[1] = '{4'b1000, 4'b0111, 5'b10001, 1'b1};   // -8 - 7    = -15
      vecs[2] = '{4'b0111, 4'b1000, 5'b01111, 1'b1};   //  7 - (-8) = +15
      vecs[3] = '{4'b1000, 4'b1000, 5'b00000, 1'b0};   // -8 - (-8) = 0
      vecs[4] = '{4'b0101, 4'b1101, 5'b01000, 1'b1};   //  5 - (-3) = +8
      vecs[5] = '{4'b1111, 4'b0001, 5'b11110, 1'b0};   // -1 - 1    = -2
      vecs[6] = '{4'b0000, 4'b0111, 5'b11001, 1'b0};   //  0 - 7    = -7
      vecs[7] = '{4'b0110, 4'b0010, 5'b00100, 1'b0};   //  6 - 2    = +4

      rst_n  = 1'b0;
      enable = 1'b0;
      a      = '0;
      b      = '0;
      repeat (3) @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset valid", 32'(valid), 32'd0);
      check("reset result", 32'(result), 32'd0);
`ifdef SUB_SERIAL_OVF_FLAG_EN
      check("reset ovf_n", 32'(ovf_n), 32'd0);
`endif
      rst_n = 1'b1;

      // Main table.
      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].va, vecs[i].vb, vecs[i].exp, vecs[i].exp_ovf, $sformatf("vec%0d", i));
      end

      // Back-to-back with enable held high; operands disturbed while each op is in flight.
      @(negedge clk);
      a = 4'b0001;
      b = 4'b0001;
      enable = 1'b1;
      last_cyc = 0;
      for (int k = 0; k < 3; k++) begin
         wait_valid(lat);
         check($sformatf("b2b%0d valid_seen", k), 32'(lat != 0), 32'd1);
         check($sformatf("b2b%0d result", k), 32'(result), 32'd0);
         if (k > 0) begin
            check($sformatf("b2b%0d spacing", k), 32'(cyc - last_cyc), 32'd6);
         end
         last_cyc = cyc;
         if (k == 2) begin
            enable = 1'b0;
         end
         @(negedge clk);
         if (k < 2) begin
            a = 4'b0111;
            b = 4'b1000;
            @(negedge clk);
            @(negedge clk);
            a = 4'b0001;
            b = 4'b0001;
         end
      end

      // Reset in the middle of RUN.
      run_op(4'b0111, 4'b1000, 5'b01111, 1'b1, "pre_rst");
      @(negedge clk);
      a = 4'b0101;
      b = 4'b1101;
      enable = 1'b1;
      @(posedge clk);
      #1;
      enable = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst valid", 32'(valid), 32'd0);
      check("midrst result", 32'(result), 32'd0);
`ifdef SUB_SERIAL_OVF_FLAG_EN
      check("midrst ovf_n", 32'(ovf_n), 32'd0);
`endif
      #4;
      rst_n = 1'b1;
      bad_valid = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (valid !== 1'b0 || busy !== 1'b0 || result !== 5'b00000) begin
            bad_valid++;
         end
      end
      check("postrst quiet", 32'(bad_valid), 32'd0);
      run_op(4'b1111, 4'b0001, 5'b11110, 1'b0, "postrst_op");

      // Result holds with enable low.
      run_op(4'b0011, 4'b1110, 5'b00101, 1'b0, "hold_op");
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check($sformatf("hold%0d result", i), 32'(result), 32'h05);
         check($sformatf("hold%0d valid", i), 32'(valid), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
